// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, ALU op codes, forward selects.
package riscv_pkg;

    localparam int DEF_XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage; unlisted op codes yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    // Operation select; add/sub wrap naturally at XLEN bits
    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution, EX/MEM register
// and a saturating taken-branch counter.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int BRCNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ValidE,
    input  logic               RegWriteE,
    input  logic               ALUSrcE,
    input  logic               MemWriteE,
    input  logic               ResultSrcE,
    input  logic               BranchE,
    input  logic [2:0]         ALUControlE,
    input  logic [XLEN-1:0]    RD1_E,
    input  logic [XLEN-1:0]    RD2_E,
    input  logic [XLEN-1:0]    Imm_Ext_E,
    input  logic [4:0]         RD_E,
    input  logic [XLEN-1:0]    PCE,
    input  logic [XLEN-1:0]    PCPlus4E,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [XLEN-1:0]    ResultW,
    input  logic               StallM,
    input  logic               FlushM,
    output logic               PCSrcE,
    output logic [XLEN-1:0]    PCTargetE,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic               ResultSrcM,
    output logic               ValidM,
    output logic [4:0]         RD_M,
    output logic [XLEN-1:0]    ALU_ResultM,
    output logic [XLEN-1:0]    WriteDataM,
    output logic [XLEN-1:0]    PCPlus4M,
    output logic [BRCNT_W-1:0] BranchCount
);

    logic [XLEN-1:0]    w_src_a;
    logic [XLEN-1:0]    w_src_b;
    logic [XLEN-1:0]    w_write_data;
    logic [XLEN-1:0]    w_alu_result;
    logic               w_zero;
    logic               w_pcsrc;

    logic               r_valid;
    logic               r_reg_write;
    logic               r_mem_write;
    logic               r_result_src;
    logic [4:0]         r_rd;
    logic [XLEN-1:0]    r_alu_result;
    logic [XLEN-1:0]    r_write_data;
    logic [XLEN-1:0]    r_pc_plus4;
    logic [BRCNT_W-1:0] r_branch_count;

    // Forwarding muxes; select 11 falls back to the regfile value
    always_comb begin
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_alu_result;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_WB:  w_write_data = ResultW;
            FWD_MEM: w_write_data = r_alu_result;
            default: w_write_data = RD2_E;
        endcase
        w_src_b = ALUSrcE ? Imm_Ext_E : w_write_data;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .A          (w_src_a),
        .B          (w_src_b),
        .ALUControl (ALUControlE),
        .Result     (w_alu_result),
        .Zero       (w_zero)
    );

    // Redirect only in the cycle the branch actually advances, so a stalled
    // branch produces exactly one pulse when it is released.
    assign w_pcsrc   = ValidE & BranchE & w_zero & ~StallM & ~rst;
    assign PCSrcE    = w_pcsrc;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM register and taken-branch counter: rst > StallM > FlushM > load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_mem_write    <= 1'b0;
            r_result_src   <= 1'b0;
            r_rd           <= '0;
            r_alu_result   <= '0;
            r_write_data   <= '0;
            r_pc_plus4     <= '0;
            r_branch_count <= '0;
        end else if (!StallM) begin
            // A flush only kills the control bits; data fields load as usual
            r_valid        <= ValidE & ~FlushM;
            r_reg_write    <= RegWriteE & ValidE & ~FlushM;
            r_mem_write    <= MemWriteE & ValidE & ~FlushM;
            r_result_src   <= ResultSrcE;
            r_rd           <= RD_E;
            r_alu_result   <= w_alu_result;
            r_write_data   <= w_write_data;
            r_pc_plus4     <= PCPlus4E;
            if (w_pcsrc && (r_branch_count != {BRCNT_W{1'b1}})) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
        end
    end

    assign ValidM      = r_valid;
    assign RegWriteM   = r_reg_write;
    assign MemWriteM   = r_mem_write;
    assign ResultSrcM  = r_result_src;
    assign RD_M        = r_rd;
    assign ALU_ResultM = r_alu_result;
    assign WriteDataM  = r_write_data;
    assign PCPlus4M    = r_pc_plus4;
    assign BranchCount = r_branch_count;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed vectors with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_execute_cycle;

    localparam int XL = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]    ALUControlE;
    logic [XL-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]    RD_E;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallM, FlushM;
    logic          PCSrcE;
    logic [XL-1:0] PCTargetE;
    logic          RegWriteM, MemWriteM, ResultSrcM, ValidM;
    logic [4:0]    RD_M;
    logic [XL-1:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic [BW-1:0] BranchCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(XL), .BRCNT_W(BW)) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1_E(RD1_E),
        .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .StallM(StallM), .FlushM(FlushM), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ValidM(ValidM), .RD_M(RD_M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .BranchCount(BranchCount)
    );

    // ---------------- behavioural model ----------------
    bit            m_ok = 0;
    logic          m_valid, m_rw, m_mw, m_rs;
    logic [4:0]    m_rd;
    logic [XL-1:0] m_alu, m_wd, m_pc4;
    int            m_cnt;

    function automatic logic [XL-1:0] pick(input logic [1:0] sel, input logic [XL-1:0] rf,
                                           input logic [XL-1:0] wb, input logic [XL-1:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return rf;
    endfunction

    function automatic logic [XL-1:0] alu_ref(input logic [2:0] op, input logic [XL-1:0] a,
                                              input logic [XL-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return XL'((64'(a) + 64'(b)) % (64'd1 << XL));
            3'd1: return XL'((64'(a) + (64'd1 << XL) - 64'(b)) % (64'd1 << XL));
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [XL-1:0] exp_wd();
        return pick(ForwardBE, RD2_E, ResultW, m_alu);
    endfunction

    function automatic logic [XL-1:0] exp_result();
        logic [XL-1:0] a, b;
        a = pick(ForwardAE, RD1_E, ResultW, m_alu);
        b = ALUSrcE ? Imm_Ext_E : exp_wd();
        return alu_ref(ALUControlE, a, b);
    endfunction

    function automatic logic exp_pcsrc();
        return ValidE && BranchE && (exp_result() == 0) && !StallM && !rst;
    endfunction

    // Model state advance on each active edge
    always @(posedge clk) begin
        logic [XL-1:0] r, wd;
        logic          tk;
        if (rst) begin
            m_ok = 1;
            m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0;
            m_alu = 0; m_wd = 0; m_pc4 = 0; m_cnt = 0;
        end else if (m_ok && !StallM) begin
            r  = exp_result();
            wd = exp_wd();
            tk = exp_pcsrc();
            if (tk && m_cnt < (1 << BW) - 1) m_cnt = m_cnt + 1;
            m_valid = ValidE && !FlushM;
            m_rw    = RegWriteE && ValidE && !FlushM;
            m_mw    = MemWriteE && ValidE && !FlushM;
            m_rs    = ResultSrcE;
            m_rd    = RD_E;
            m_alu   = r;
            m_wd    = wd;
            m_pc4   = PCPlus4E;
        end
    end

    task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison on the inactive edge
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_ValidM",      XL'(ValidM),      XL'(m_valid));
            chk("m_RegWriteM",   XL'(RegWriteM),   XL'(m_rw));
            chk("m_MemWriteM",   XL'(MemWriteM),   XL'(m_mw));
            chk("m_ResultSrcM",  XL'(ResultSrcM),  XL'(m_rs));
            chk("m_RD_M",        XL'(RD_M),        XL'(m_rd));
            chk("m_ALU_ResultM", ALU_ResultM,      m_alu);
            chk("m_WriteDataM",  WriteDataM,       m_wd);
            chk("m_PCPlus4M",    PCPlus4M,         m_pc4);
            chk("m_BranchCount", XL'(BranchCount), XL'(m_cnt));
            chk("m_PCSrcE",      XL'(PCSrcE),      XL'(exp_pcsrc()));
            chk("m_PCTargetE",   PCTargetE,        XL'(64'(PCE) + 64'(Imm_Ext_E)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ValidE = 0; RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
        RD_E = 0; PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
        StallM = 0; FlushM = 0;
    endtask

    task automatic rand_inputs();
        ValidE = 1'($urandom); RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom);
        MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom); BranchE = 1'($urandom);
        ALUControlE = 3'($urandom); RD1_E = $urandom; RD2_E = $urandom;
        Imm_Ext_E = $urandom; RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = PCE + 4;
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
        StallM = 1'($urandom); FlushM = 1'($urandom);
    endtask

    task automatic set_branch();
        quiet();
        ValidE = 1; BranchE = 1; ALUControlE = 3'b001; RD1_E = 7; RD2_E = 7;
        PCE = 32'h100; PCPlus4E = 32'h104; Imm_Ext_E = 32'h20;
    endtask

    logic [XL-1:0] held_alu;

    initial begin
        quiet();
        rst = 1;
        rand_inputs();
        BranchE = 1; ValidE = 1; StallM = 0; ALUControlE = 3'b010; RD1_E = 0;
        cyc();
        rand_inputs();
        cyc();
        chk("rst_ValidM", XL'(ValidM), 0);
        chk("rst_ALU_ResultM", ALU_ResultM, 0);
        chk("rst_BranchCount", XL'(BranchCount), 0);
        chk("rst_PCSrcE", XL'(PCSrcE), 0);
        $display("txn reset done");

        // add with negative immediate
        rst = 0; quiet();
        ValidE = 1; RD1_E = 5; Imm_Ext_E = 32'hFFFF_FFFD; ALUSrcE = 1; RegWriteE = 1; RD_E = 3;
        cyc();
        chk("add_ALU_ResultM", ALU_ResultM, 2);
        chk("add_RD_M", XL'(RD_M), 3);
        chk("add_RegWriteM", XL'(RegWriteM), 1);
        chk("add_ValidM", XL'(ValidM), 1);
        $display("txn add 5+(-3) -> %0d", ALU_ResultM);

        // signed slt
        quiet(); ValidE = 1; ALUControlE = 3'b101; RD1_E = 32'h8000_0000; RD2_E = 1;
        cyc();
        chk("slt_ALU_ResultM", ALU_ResultM, 1);
        $display("txn slt -> %0d", ALU_ResultM);

        // forwarding: produce 4, then sub with WB/MEM forwarding
        quiet(); ValidE = 1; RD1_E = 4; ALUSrcE = 1;
        cyc();
        quiet(); ValidE = 1; ALUControlE = 3'b001; ForwardAE = 2'b01; ResultW = 32'h10;
        ForwardBE = 2'b10; RD1_E = 32'hDEAD; RD2_E = 32'hBEEF;
        cyc();
        chk("fwd_ALU_ResultM", ALU_ResultM, 32'hC);
        chk("fwd_WriteDataM", WriteDataM, 32'h4);
        $display("txn forward sub -> 0x%0h wd 0x%0h", ALU_ResultM, WriteDataM);

        // taken beq
        set_branch(); #1;
        chk("br_PCSrcE", XL'(PCSrcE), 1);
        chk("br_PCTargetE", PCTargetE, 32'h120);
        cyc();
        chk("br_BranchCount", XL'(BranchCount), 1);
        $display("txn beq taken count %0d", BranchCount);

        // stalled branch: no pulse, M holds; single pulse on release
        held_alu = ALU_ResultM;
        set_branch(); StallM = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_PCSrcE", XL'(PCSrcE), 0);
            cyc();
            chk("stall_BranchCount", XL'(BranchCount), 1);
            chk("stall_ALU_ResultM", ALU_ResultM, held_alu);
        end
        StallM = 0; #1;
        chk("release_PCSrcE", XL'(PCSrcE), 1);
        cyc();
        quiet(); #1;
        chk("release_PCSrcE_off", XL'(PCSrcE), 0);
        cyc();
        chk("release_BranchCount", XL'(BranchCount), 2);
        $display("txn stalled beq released count %0d", BranchCount);

        // flush kills control
        quiet(); ValidE = 1; RegWriteE = 1; MemWriteE = 1; FlushM = 1;
        cyc();
        chk("flush_ValidM", XL'(ValidM), 0);
        chk("flush_RegWriteM", XL'(RegWriteM), 0);
        chk("flush_MemWriteM", XL'(MemWriteM), 0);
        // valid load then stall+flush holds it
        quiet(); ValidE = 1; RegWriteE = 1; RD_E = 9; RD1_E = 11; ALUSrcE = 1;
        cyc();
        quiet(); StallM = 1; FlushM = 1; RD_E = 1;
        cyc();
        chk("stflush_ValidM", XL'(ValidM), 1);
        chk("stflush_RegWriteM", XL'(RegWriteM), 1);
        chk("stflush_RD_M", XL'(RD_M), 9);
        // invalid instruction never writes
        quiet(); ValidE = 0; RegWriteE = 1;
        cyc();
        chk("invalid_RegWriteM", XL'(RegWriteM), 0);
        $display("txn flush/stall priority checked");

        // reset during stall
        quiet(); ValidE = 1; RegWriteE = 1; cyc();
        StallM = 1; rst = 1;
        cyc();
        chk("rststall_ValidM", XL'(ValidM), 0);
        chk("rststall_BranchCount", XL'(BranchCount), 0);
        rst = 0;
        $display("txn reset mid-stall");

        // saturation: 17 consecutive taken branches into a 4-bit counter
        set_branch();
        for (int i = 0; i < 17; i++) cyc();
        chk("sat_BranchCount", XL'(BranchCount), 32'hF);
        cyc();
        chk("sat_BranchCount2", XL'(BranchCount), 32'hF);
        $display("txn saturation count %0d", BranchCount);

        // random traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
            rst = ($urandom_range(0, 40) == 0);
            cyc();
        end
        quiet(); rst = 0;
        cyc();
        $display("txn random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline; consumes the E-stage bundle produced by decode_cycle (control bits, operands, immediate, register indices, PC values).
- Applies operand forwarding, performs the ALU operation and resolves beq.
- Drives the PC redirect back to the fetch stage and loads the EX/MEM pipeline register.
- Registers write address and data that reach the regfile write port two stages later.

Parameters:
- XLEN, 32, datapath width.
- BRCNT_W, 16, width of taken-branch performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ValidE  in  1  E-stage holds a real instruction
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  control from decode
- ALUControlE  in  3  ALU op
- RD1_E, RD2_E, Imm_Ext_E  in  XLEN  operands, immediate
- RD_E  in  5  destination register index
- PCE, PCPlus4E  in  XLEN  instruction PC, PC+4
- ForwardAE, ForwardBE  in  2  00 regfile, 01 ResultW, 10 ALU_ResultM, 11 treated as 00
- ResultW  in  XLEN  writeback value
- StallM  in  1  hold EX/MEM register
- FlushM  in  1  load bubble into EX/MEM
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  PCE + Imm_Ext_E (combinational)
- RegWriteM, MemWriteM, ResultSrcM, ValidM  out  1 each  registered control
- RD_M  out  5
- ALU_ResultM, WriteDataM, PCPlus4M  out  XLEN
- BranchCount  out  BRCNT_W  taken branches retired

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset, sampled on a clk edge with rst=1: every registered output is 0, including BranchCount.
- Combinational outputs during reset follow their inputs. PCSrcE is forced to 0 while rst=1.

Forwarding:
- SrcA = mux(ForwardAE).
- WriteDataE = mux(ForwardBE), the forwarded RD2 value.
- SrcB = ALUSrcE ? Imm_Ext_E : WriteDataE.

ALU:
- 000 add; 001 sub; 010 and; 011 or; 101 slt, signed, result 0 or 1.
- Any other code gives result 0.
- Arithmetic wraps modulo 2^XLEN.
- ZeroE = (ALUResultE == 0).

Branch:
- PCSrcE = ValidE & BranchE & ZeroE & ~StallM & ~rst.
- Asserted only in the cycle the instruction advances, so each redirect pulses exactly once.
- PCTargetE is always computed; it wraps modulo 2^XLEN.

EX/MEM register, priority rst > StallM > FlushM > load:
- StallM=1: all M outputs and BranchCount hold. FlushM is ignored in that cycle.
- FlushM=1, StallM=0: ValidM=0, RegWriteM=0, MemWriteM=0. Data fields load normally; their values are don't-care but deterministic.
- Load:
  - ValidM <= ValidE.
  - RegWriteM <= RegWriteE & ValidE; MemWriteM <= MemWriteE & ValidE.
  - ResultSrcM, RD_M, PCPlus4M, ALU_ResultM, WriteDataM load from E.

Latency and counter:
- Latency E→M is one cycle.
- BranchCount increments when PCSrcE=1. It saturates at all-ones; no wrap.
- Reset mid-stall: reset wins; the next cycle starts from the bubble state.

Decomposition:
- Shared package riscv_pkg:
  - ALU op constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - Forward-select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - XLEN default.
- One sub-module: alu (inputs A, B, ALUControl; outputs Result, Zero), purely combinational.
- Forwarding muxes, branch logic, EX/MEM register and counter live in execute_cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs → all M outputs 0, BranchCount=0, PCSrcE=0.
- ALU and load:
  - Inputs: ValidE=1, RD1_E=5, Imm_Ext_E=0xFFFFFFFD, ALUSrcE=1, add, RegWriteE=1, RD_E=3.
  - Next cycle: ALU_ResultM=2, RD_M=3, RegWriteM=1, ValidM=1.
  - Then slt with RD1_E=0x80000000, RD2_E=1, ALUSrcE=0 → ALU_ResultM=1.
- Forwarding:
  - ForwardAE=01, ResultW=0x10, ForwardBE=10, previous ALU_ResultM=0x4, sub → ALU_ResultM=0xC.
  - Same cycle: WriteDataM=0x4.
- Branch:
  - Inputs: beq with RD1_E=RD2_E=7, BranchE=1, sub, PCE=0x100, Imm_Ext_E=0x20.
  - Response: PCSrcE=1, PCTargetE=0x120, BranchCount increments by 1.
  - Same branch with StallM=1 for 3 cycles → PCSrcE=0 during the stall and the M outputs hold. On release: a single PCSrcE pulse and count +1 only.
- Flush and stall priority:
  - FlushM=1 with RegWriteE=MemWriteE=1 → ValidM=0, RegWriteM=0, MemWriteM=0.
  - StallM=1 & FlushM=1 together → M outputs unchanged.
  - ValidE=0 with RegWriteE=1 → RegWriteM=0.
- Saturation: preload BranchCount to 0xFFFF via repeated taken branches (or BRCNT_W=2 build), issue one more taken branch → count stays all-ones.
